core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM sequencing the waverv datapath: fetch, decode, execute, memory, writeback.
//  Owns the program counter and the single shared memory port (req/ack handshake) used by fetch and load/store.
//  Gates instruction-register load and register-file write; halts on illegal/misaligned/timeout faults.
// PARAMETERS
//  RESET_VECTOR    32'h0000_0000  PC value loaded on reset
//  ACK_TIMEOUT     16             max cycles a memory request may wait for ack before fault (>=1)
// PORTS
//  clk                    in   1   core clock; all state updates on rising edge
//  rst                    in   1   synchronous, active-high reset
//  instr_is_load          in   1   decoded instruction is a load (valid from DECODE onward)
//  instr_is_store         in   1   decoded instruction is a store
//  instr_illegal          in   1   decoder could not classify instruction
//  branch_taken           in   1   redirect PC at writeback
//  branch_target          in   32  redirect address
//  data_address           in   32  load/store effective address (ALU result)
//  mem_ack                in   1   memory completes current request this cycle
//  mem_req                out  1   memory request valid
//  mem_write_enable       out  1   request is a store
//  mem_address            out  32  request address
//  ir_load_enable         out  1   one-cycle pulse: capture fetched word into IR
//  register_write_enable  out  1   one-cycle writeback gate to register file
//  program_counter        out  32  address of current instruction
//  retired_count          out  32  instructions retired, wraps at 2^32
//  halted                 out  1   sticky fault indication
//  halt_cause             out  2   0 none, 1 illegal, 2 misaligned, 3 ack timeout
// BEHAVIOUR
//  Reset: state=FETCH, program_counter=RESET_VECTOR, retired_count=0, halted=0, halt_cause=0,
//   mem_req=0, mem_write_enable=0, mem_address=0, ir_load_enable=0, register_write_enable=0.
//   rst mid-operation abandons any outstanding request; an ack in the cycle rst is high is ignored.
//  States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
//  FETCH: mem_req=1, mem_write_enable=0, mem_address=program_counter; on mem_ack pulse ir_load_enable
//   in that cycle, go DECODE. program_counter[1:0]!=0 -> HALT cause 2, no request issued.
//  DECODE: 1 cycle. instr_illegal -> HALT cause 1; else EXECUTE.
//  EXECUTE: 1 cycle (ALU settle). load|store -> MEMORY (data_address[1:0]!=0 -> HALT cause 2); else WRITEBACK.
//  MEMORY: mem_req=1, mem_address=data_address, mem_write_enable=instr_is_store; on ack -> WRITEBACK.
//  WRITEBACK: register_write_enable=!instr_is_store for exactly this cycle; program_counter <=
//   branch_taken ? branch_target : program_counter+4 (mod 2^32); retired_count++; -> FETCH.
//  Handshake: mem_req/address/write_enable held stable until ack; ack while mem_req=0 ignored.
//   Ack in first request cycle allowed (FETCH->DECODE minimum 1 cycle). Min CPI 4 (ALU), 5 (load/store).
//  Timeout: wait counter clears on entering FETCH/MEMORY, increments each unacked req cycle; ack in
//   cycle ACK_TIMEOUT still completes; reaching ACK_TIMEOUT unacked cycles -> HALT cause 3.
//  HALT: mem_req=0, all enables 0, PC and retired_count frozen; exits only via rst.
//  halted/halt_cause registered: assert the cycle after the fault is detected.
// STRUCTURE
//  waverv_pkg: sequencer state enum, halt-cause codes, RESET_VECTOR default, PC_STEP=4.
//  Sub-module ack_timeout_counter (clear, count_enable, ack -> expired) instantiated once.
//  FSM, PC and retired counter stay in core_sequencer; outputs decoded from registered state.
// TESTING
//  1 rst, then ack every request immediately, ALU ops -> PC 0,4,8..; ir_load pulses every 4 cycles; retired=3 after 12.
//  2 load at PC 0x10, data_address 0x100, ack after 3 cycles -> mem_address=0x100, we=0, wb pulse, PC=0x14.
//  3 store, data_address 0x200 -> mem_write_enable=1 held until ack; register_write_enable stays 0.
//  4 branch_taken=1, target 0x40 at WRITEBACK -> next fetch mem_address=0x40; target 0x42 -> halt_cause 2.
//  5 never ack, ACK_TIMEOUT=16 -> halted=1, cause 3 after 16 req cycles; ack in cycle 16 -> no halt.
//  6 instr_illegal in DECODE -> cause 1, mem_req 0; rst during MEMORY wait -> PC=RESET_VECTOR, halted 0.

Source files
------------

// File: rtl/waverv_pkg.sv
// -----------------------------------------------------------------------------
// waverv_pkg
// Shared definitions for the waverv control sequencer.
//   seq_state_e   : sequencer FSM states
//   halt_cause_e  : fault codes reported on halt_cause
//   DEFAULT_RESET_VECTOR, PC_STEP : program counter constants
//   is_misaligned : word-alignment test on the two low address bits
// -----------------------------------------------------------------------------
package waverv_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } seq_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_ILLEGAL    = 2'd1,
      CAUSE_MISALIGNED = 2'd2,
      CAUSE_TIMEOUT    = 2'd3
   } halt_cause_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP              = 32'd4;

   // Only the two low bits matter for word alignment.
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/ack_timeout_counter.sv
// -----------------------------------------------------------------------------
// ack_timeout_counter
// Counts consecutive unacknowledged memory request cycles and flags the cycle
// in which the ACK_TIMEOUT-th unacknowledged request cycle occurs.
// Ports:
//   clk            in  core clock
//   rst            in  synchronous active-high reset
//   clear_i        in  restart the count (a new request phase is being entered)
//   count_enable_i in  a request is being presented this cycle
//   ack_i          in  memory acknowledges this cycle
//   expired_o      out this request cycle is the ACK_TIMEOUT-th one without ack
// -----------------------------------------------------------------------------
module ack_timeout_counter #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic count_enable_i,
   input  logic ack_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(ACK_TIMEOUT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_enable_i && !ack_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q holds the unacked cycles already seen, so the current cycle is
   // number count_q+1. An ack in the final allowed cycle still wins. clear_i is
   // deliberately not used here: it is derived from the FSM next state, which
   // itself depends on expired_o.
   assign expired_o = count_enable_i && !ack_i && (count_q == LAST_WAIT);

endmodule

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM for the waverv datapath: FETCH, DECODE, EXECUTE,
// MEMORY, WRITEBACK, with a sticky HALT on illegal instruction, misaligned
// address or memory ack timeout. Owns the program counter, the retired
// instruction counter and the single shared req/ack memory port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_is_load/_store     decoded class (valid from DECODE onward)
//   instr_illegal            decoder could not classify the instruction
//   branch_taken/_target     PC redirect applied at WRITEBACK
//   data_address             load/store effective address
//   mem_ack                  memory completes the current request
//   mem_req/_write_enable/_address  memory request port
//   ir_load_enable           capture fetched word into IR (ack cycle of fetch)
//   register_write_enable    writeback gate to register file
//   program_counter          address of the current instruction
//   retired_count            retired instructions (wraps)
//   halted, halt_cause       sticky fault flag and code
// -----------------------------------------------------------------------------
module core_sequencer
   import waverv_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned ACK_TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_is_load,
   input  logic        instr_is_store,
   input  logic        instr_illegal,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] data_address,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_write_enable,
   output logic [31:0] mem_address,
   output logic        ir_load_enable,
   output logic        register_write_enable,
   output logic [31:0] program_counter,
   output logic [31:0] retired_count,
   output logic        halted,
   output logic [1:0]  halt_cause
);

   seq_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] retired_q, retired_d;
   logic        halted_q, halted_d;
   halt_cause_e halt_cause_q, halt_cause_d;

   logic        timeout_expired;
   logic        wait_clear;

   // The wait counter restarts whenever the FSM moves to a different state,
   // which covers every entry into FETCH and MEMORY.
   assign wait_clear = (state_d != state_q);

   ack_timeout_counter #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timeout (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (wait_clear),
      .count_enable_i (mem_req),
      .ack_i          (mem_ack),
      .expired_o      (timeout_expired)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_VECTOR;
         retired_q    <= '0;
         halted_q     <= 1'b0;
         halt_cause_q <= CAUSE_NONE;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         retired_q    <= retired_d;
         halted_q     <= halted_d;
         halt_cause_q <= halt_cause_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      retired_d    = retired_q;
      halted_d     = halted_q;
      halt_cause_d = halt_cause_q;

      case (state_q)
         ST_FETCH: begin
            // A misaligned PC faults before any request goes out.
            if (is_misaligned(pc_q[1:0])) begin
               state_d      = ST_HALT;
               halted_d     = 1'b1;
               halt_cause_d = CAUSE_MISALIGNED;
            end else if (mem_ack) begin
               state_d = ST_DECODE;
            end else if (timeout_expired) begin
               state_d      = ST_HALT;
               halted_d     = 1'b1;
               halt_cause_d = CAUSE_TIMEOUT;
            end
         end

         ST_DECODE: begin
            if (instr_illegal) begin
               state_d      = ST_HALT;
               halted_d     = 1'b1;
               halt_cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = ST_EXECUTE;
            end
         end

         ST_EXECUTE: begin
            if (instr_is_load || instr_is_store) begin
               if (is_misaligned(data_address[1:0])) begin
                  state_d      = ST_HALT;
                  halted_d     = 1'b1;
                  halt_cause_d = CAUSE_MISALIGNED;
               end else begin
                  state_d = ST_MEMORY;
               end
            end else begin
               state_d = ST_WRITEBACK;
            end
         end

         ST_MEMORY: begin
            if (mem_ack) begin
               state_d = ST_WRITEBACK;
            end else if (timeout_expired) begin
               state_d      = ST_HALT;
               halted_d     = 1'b1;
               halt_cause_d = CAUSE_TIMEOUT;
            end
         end

         ST_WRITEBACK: begin
            pc_d      = branch_taken ? branch_target : pc_q + PC_STEP;
            retired_d = retired_q + 32'd1;
            state_d   = ST_FETCH;
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // ---------------- output decode ----------------
   // Outputs are forced idle while rst is high so an abandoned request is
   // dropped immediately and a coincident ack has nothing to complete.
   always_comb begin
      mem_req               = 1'b0;
      mem_write_enable      = 1'b0;
      mem_address           = '0;
      ir_load_enable        = 1'b0;
      register_write_enable = 1'b0;

      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               if (!is_misaligned(pc_q[1:0])) begin
                  mem_req        = 1'b1;
                  mem_address    = pc_q;
                  ir_load_enable = mem_ack;
               end
            end

            ST_MEMORY: begin
               mem_req          = 1'b1;
               mem_address      = data_address;
               mem_write_enable = instr_is_store;
            end

            ST_WRITEBACK: begin
               register_write_enable = !instr_is_store;
            end

            default: begin
            end
         endcase
      end
   end

   assign program_counter = pc_q;
   assign retired_count   = retired_q;
   assign halted          = halted_q;
   assign halt_cause      = halt_cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
// Directed bench for core_sequencer. Expected memory transactions are pushed to
// a scoreboard queue as stimulus is set up and popped when the DUT presents the
// corresponding request; PC and retired count follow a small reference model.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_is_load;
   logic        instr_is_store;
   logic        instr_illegal;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] data_address;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_write_enable;
   logic [31:0] mem_address;
   logic        ir_load_enable;
   logic        register_write_enable;
   logic [31:0] program_counter;
   logic [31:0] retired_count;
   logic        halted;
   logic [1:0]  halt_cause;

   always #5 clk = ~clk;

   core_sequencer #(
      .RESET_VECTOR (32'h0000_0000),
      .ACK_TIMEOUT  (16)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .instr_is_load         (instr_is_load),
      .instr_is_store        (instr_is_store),
      .instr_illegal         (instr_illegal),
      .branch_taken          (branch_taken),
      .branch_target         (branch_target),
      .data_address          (data_address),
      .mem_ack               (mem_ack),
      .mem_req               (mem_req),
      .mem_write_enable      (mem_write_enable),
      .mem_address           (mem_address),
      .ir_load_enable        (ir_load_enable),
      .register_write_enable (register_write_enable),
      .program_counter       (program_counter),
      .retired_count         (retired_count),
      .halted                (halted),
      .halt_cause            (halt_cause)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
   } xfer_t;

   xfer_t       sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] pc_m;
   logic [31:0] ret_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Serve one request: hold ack low for 'delay' cycles, then ack. Called at a
   // negedge in the first request cycle.
   task automatic mem_xfer(input string tag, input int delay, input logic is_fetch);
      xfer_t exp;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
         return;
      end
      exp = sb_q.pop_front();
      for (int i = 0; i <= delay; i++) begin
         mem_ack = (i == delay);
         #1;
         chk1({tag, " req"}, mem_req, 1'b1);
         chk({tag, " addr"}, mem_address, exp.addr);
         chk1({tag, " we"}, mem_write_enable, exp.we);
         chk1({tag, " ir_load"}, ir_load_enable, is_fetch && (i == delay));
         tick();
      end
      mem_ack = 1'b0;
   endtask

   task automatic run_instr(input string tag, input logic ld, input logic st, input logic br,
                            input logic [31:0] tgt, input logic [31:0] daddr,
                            input int fdelay, input int mdelay);
      sb_q.push_back('{addr: pc_m, we: 1'b0});
      mem_xfer({tag, " fetch"}, fdelay, 1'b1);
      // DECODE
      instr_is_load  = ld;
      instr_is_store = st;
      instr_illegal  = 1'b0;
      data_address   = daddr;
      if (ld || st) sb_q.push_back('{addr: daddr, we: st});
      #1;
      chk1({tag, " decode req"}, mem_req, 1'b0);
      tick();
      // EXECUTE
      #1;
      chk1({tag, " execute rwe"}, register_write_enable, 1'b0);
      tick();
      if (ld || st) mem_xfer({tag, " mem"}, mdelay, 1'b0);
      // WRITEBACK
      branch_taken  = br;
      branch_target = tgt;
      #1;
      chk1({tag, " wb rwe"}, register_write_enable, !st);
      chk1({tag, " wb req"}, mem_req, 1'b0);
      tick();
      pc_m  = br ? tgt : pc_m + 32'd4;
      ret_m = ret_m + 32'd1;
      branch_taken   = 1'b0;
      instr_is_load  = 1'b0;
      instr_is_store = 1'b0;
      #1;
      chk({tag, " pc"}, program_counter, pc_m);
      chk({tag, " retired"}, retired_count, ret_m);
      chk1({tag, " rwe after wb"}, register_write_enable, 1'b0);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      mem_ack        = 1'b0;
      instr_is_load  = 1'b0;
      instr_is_store = 1'b0;
      instr_illegal  = 1'b0;
      branch_taken   = 1'b0;
      branch_target  = '0;
      data_address   = '0;
      tick();
      tick();
      #1;
      chk1("rst mem_req", mem_req, 1'b0);
      chk("rst mem_address", mem_address, 32'h0);
      chk1("rst we", mem_write_enable, 1'b0);
      chk1("rst ir_load", ir_load_enable, 1'b0);
      chk1("rst rwe", register_write_enable, 1'b0);
      chk("rst pc", program_counter, 32'h0);
      chk("rst retired", retired_count, 32'h0);
      chk1("rst halted", halted, 1'b0);
      chk("rst cause", {30'b0, halt_cause}, 32'd0);
      rst   = 1'b0;
      pc_m  = 32'h0;
      ret_m = 32'h0;
      sb_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset, then back-to-back ALU instructions with immediate acks
      do_reset();
      for (int i = 0; i < 3; i++) run_instr("alu", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
      chk("alu pc after 3", program_counter, 32'h0000_000C);
      chk("alu retired after 3", retired_count, 32'd3);
      run_instr("alu4", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);

      // 2: load at PC 0x10, ack after 3 wait cycles
      chk("load start pc", program_counter, 32'h0000_0010);
      run_instr("load", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 0, 3);
      chk("load end pc", program_counter, 32'h0000_0014);

      // 3: store, write enable held through the wait
      run_instr("store", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0200, 1, 2);

      // 4: branch to 0x40, then branch to misaligned 0x42
      run_instr("br40", 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 0, 0);
      run_instr("br42", 1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 0, 0);
      chk1("misalign fetch req", mem_req, 1'b0);
      chk1("misalign halted pre", halted, 1'b0);
      tick();
      #1;
      chk1("misalign halted", halted, 1'b1);
      chk("misalign cause", {30'b0, halt_cause}, 32'd2);
      tick();
      tick();
      #1;
      chk1("misalign halt req", mem_req, 1'b0);
      chk("misalign frozen pc", program_counter, 32'h0000_0042);
      chk("misalign frozen retired", retired_count, ret_m);

      // 5: ack in cycle 16 completes; never acking times out after 16 cycles
      do_reset();
      run_instr("ack16", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 15, 0);
      chk1("ack16 no halt", halted, 1'b0);
      for (int i = 0; i < 16; i++) begin
         #1;
         chk1("timeout waiting req", mem_req, 1'b1);
         chk1("timeout waiting halted", halted, 1'b0);
         tick();
      end
      #1;
      chk1("timeout halted", halted, 1'b1);
      chk("timeout cause", {30'b0, halt_cause}, 32'd3);
      chk1("timeout req", mem_req, 1'b0);
      chk("timeout pc", program_counter, pc_m);

      // 6a: illegal instruction in DECODE
      do_reset();
      sb_q.push_back('{addr: pc_m, we: 1'b0});
      mem_xfer("illegal fetch", 0, 1'b1);
      instr_illegal = 1'b1;
      tick();
      instr_illegal = 1'b0;
      #1;
      chk1("illegal halted", halted, 1'b1);
      chk("illegal cause", {30'b0, halt_cause}, 32'd1);
      chk1("illegal req", mem_req, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      #1;
      chk1("illegal stays req", mem_req, 1'b0);
      chk("illegal frozen pc", program_counter, 32'h0);

      // 6b: reset while a load waits in MEMORY, with a coincident ack
      do_reset();
      run_instr("pre", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
      sb_q.push_back('{addr: pc_m, we: 1'b0});
      mem_xfer("abort fetch", 0, 1'b1);
      instr_is_load = 1'b1;
      data_address  = 32'h0000_0300;
      tick();
      tick();
      #1;
      chk1("abort mem req", mem_req, 1'b1);
      chk("abort mem addr", mem_address, 32'h0000_0300);
      tick();
      rst     = 1'b1;
      mem_ack = 1'b1;
      tick();
      #1;
      chk1("abort rst req", mem_req, 1'b0);
      chk("abort pc", program_counter, 32'h0);
      chk("abort retired", retired_count, 32'h0);
      chk1("abort halted", halted, 1'b0);
      rst           = 1'b0;
      mem_ack       = 1'b0;
      instr_is_load = 1'b0;
      #1;
      chk1("abort refetch req", mem_req, 1'b1);
      chk("abort refetch addr", mem_address, 32'h0);
      chk1("abort refetch ir", ir_load_enable, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
